// File: rtl/time_set_controller.sv
// time_set_controller: time-of-day registers, debounced MODE/INC set-mode FSM and field blink blanking.
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int HOUR_MAX        = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blank_h,
    output logic       blank_m,
    output logic       blank_s
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

    state_t          state, state_nx;
    logic   [1:0]    raw, press;
    logic            press_mode, press_inc, inc_ok, blink_phase;
    logic   [BW-1:0] blink_cnt;

    assign raw = {btn_inc, btn_mode};

    // Per button: 2-flop synchronizer, stability counter, rising edge of accepted level.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic          s1, s2, lvl, lvl_q;
        logic [DW-1:0] cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                lvl   <= 1'b0;
                lvl_q <= 1'b0;
                cnt   <= '0;
            end else begin
                s1    <= raw[i];
                s2    <= s1;
                lvl_q <= lvl;
                if (s2 == lvl)
                    cnt <= '0;
                else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt <= '0;
                    lvl <= s2;
                end else
                    cnt <= cnt + 1'b1;
            end
        end
        assign press[i] = lvl & ~lvl_q;
    end

    assign press_mode = press[0];
    assign press_inc  = press[1];
    assign inc_ok     = press_inc & ~press_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = press_mode ? state_t'(state + 2'd1) : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hours   <= '0;
            minutes <= '0;
            seconds <= '0;
        end else if (state == RUN && tick) begin
            seconds <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
            if (seconds == 6'd59) begin
                minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                if (minutes == 6'd59)
                    hours <= (hours == 5'(HOUR_MAX)) ? 5'd0 : hours + 5'd1;
            end
        end else if (inc_ok) begin
            if (state == SET_H)
                hours <= (hours == 5'(HOUR_MAX)) ? 5'd0 : hours + 5'd1;
            if (state == SET_M)
                minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            if (state == SET_S)
                seconds <= 6'd0;
        end
    end

    // Any press restarts the blink so the edited field is visible straight away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (press_mode | press_inc) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else
            blink_cnt <= blink_cnt + 1'b1;
    end

    assign mode    = state;
    assign blank_h = (state == SET_H) & blink_phase;
    assign blank_m = (state == SET_M) & blink_phase;
    assign blank_s = (state == SET_S) & blink_phase;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed checks of time keeping, set mode, debouncing and blinking.
module tb_time_set_controller;
    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [1:0] mode;
    logic       blank_h, blank_m, blank_s;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    time_set_controller #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8), .HOUR_MAX(23)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hours(hours), .minutes(minutes), .seconds(seconds), .mode(mode),
        .blank_h(blank_h), .blank_m(blank_m), .blank_s(blank_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".h"}, 32'(hours), h);
        check({tag, ".m"}, 32'(minutes), m);
        check({tag, ".s"}, 32'(seconds), s);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        cyc(10);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(10);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
        end
        tick = 1'b0;
    endtask

    initial begin
        cyc(2);
        check_time("reset", 0, 0, 0);
        check("reset.mode", 32'(mode), 0);
        check("reset.blank", 32'({blank_h, blank_m, blank_s}), 0);
        reset = 1'b0;
        cyc(1);
        press_btn(1'b0, 1'b1);
        check_time("run_inc_ignored", 0, 0, 0);
        ticks(3);
        check_time("run_ticks", 0, 0, 3);
        press_btn(1'b1, 1'b0);
        check("mode1", 32'(mode), 1);
        ticks(5);
        check_time("set_h_frozen", 0, 0, 3);
        btn_inc = 1'b1;
        cyc(3);
        btn_inc = 1'b0;
        cyc(15);
        check("glitch", 32'(hours), 0);
        btn_inc = 1'b1;
        cyc(6);
        check("held_pre", 32'(hours), 0);
        cyc(1);
        check("held_edge", 32'(hours), 1);
        cyc(13);
        btn_inc = 1'b0;
        cyc(10);
        check("held_once", 32'(hours), 1);
        repeat (22) press_btn(1'b0, 1'b1);
        check("hours23", 32'(hours), 23);
        press_btn(1'b0, 1'b1);
        check("hours_wrap", 32'(hours), 0);
        repeat (23) press_btn(1'b0, 1'b1);
        press_btn(1'b1, 1'b0);
        check("mode2", 32'(mode), 2);
        ticks(4);
        check_time("set_m_frozen", 23, 0, 3);
        repeat (59) press_btn(1'b0, 1'b1);
        check("min59", 32'(minutes), 59);
        press_btn(1'b0, 1'b1);
        check_time("min_wrap_nocarry", 23, 0, 3);
        repeat (59) press_btn(1'b0, 1'b1);
        press_btn(1'b1, 1'b0);
        check("mode3", 32'(mode), 3);
        ticks(2);
        check("set_s_frozen", 32'(seconds), 3);
        press_btn(1'b0, 1'b1);
        check_time("sec_clear", 23, 59, 0);
        press_btn(1'b1, 1'b0);
        check("mode0", 32'(mode), 0);
        ticks(59);
        check_time("pre_rollover", 23, 59, 59);
        ticks(1);
        check_time("rollover", 0, 0, 0);
        press_btn(1'b1, 1'b0);
        check("aligned_pre", 32'(mode), 1);
        press_btn(1'b1, 1'b1);
        check("aligned_mode", 32'(mode), 2);
        check("aligned_hours", 32'(hours), 0);
        btn_inc = 1'b1;
        cyc(7);
        check("blink_inc", 32'(minutes), 1);
        for (int i = 0; i < 24; i++) begin
            check("blank_m", 32'(blank_m), (i / 8) % 2);
            check("blank_hs", 32'({blank_h, blank_s}), 0);
            cyc(1);
        end
        btn_inc = 1'b0;
        cyc(10);
        btn_mode = 1'b1;
        cyc(3);
        reset = 1'b1;
        #1;
        check("async.mode", 32'(mode), 0);
        check_time("async", 0, 0, 0);
        check("async.blank", 32'({blank_h, blank_m, blank_s}), 0);
        btn_mode = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(15);
        check("no_press_after_reset", 32'(mode), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
